// File: rtl/oversample_filter_pkg.sv
// Shared constants for the oversample decimator: channel count, the
// write-bus address it decodes, and the default maximum oversample ratio.
package oversample_filter_pkg;

    localparam int N_CHAN     = 8;
    localparam int CHAN_IDX_W = $clog2(N_CHAN);
    localparam int OS_ADDR    = 'h0024;
    localparam int MAX_OS_CFG = 10;

endpackage

// File: rtl/oversample_filter.sv
// Per-channel block-averaging decimator: sums 2^os samples per channel and
// emits the floor-shifted average on the same dv/chan/data stream.
module oversample_filter
    import oversample_filter_pkg::*;
#(
    parameter int W_CHAN    = 5,
    parameter int W_DATA    = 18,
    parameter int MAX_OS    = MAX_OS_CFG,
    parameter int W_OS      = 4,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        dv_in,
    input  logic        [W_CHAN-1:0]    chan_in,
    input  logic signed [W_DATA-1:0]    data_in,
    input  logic                        wr_en,
    input  logic        [W_WR_ADDR-1:0] wr_addr,
    input  logic        [W_WR_CHAN-1:0] wr_chan,
    input  logic        [W_WR_DATA-1:0] wr_data,
    output logic                        dv_out,
    output logic        [W_CHAN-1:0]    chan_out,
    output logic signed [W_DATA-1:0]    data_out
);

    localparam int W_SUM = W_DATA + MAX_OS;

    function automatic logic [MAX_OS-1:0] f_win_last(input logic [W_OS-1:0] os);
        logic [MAX_OS-1:0] m;
        for (int i = 0; i < MAX_OS; i++) m[i] = (i < int'(os));
        return m;
    endfunction

    function automatic logic [W_OS-1:0] f_clamp_os(input logic [W_OS-1:0] os);
        return (int'(os) > MAX_OS) ? W_OS'(MAX_OS) : os;
    endfunction

    function automatic logic signed [W_DATA-1:0] f_avg(input logic signed [W_SUM-1:0] s,
                                                      input logic [W_OS-1:0] os);
        return W_DATA'(s >>> os);
    endfunction

    logic        [W_OS-1:0]      r_os_mem  [N_CHAN];
    logic signed [W_SUM-1:0]     r_sum_mem [N_CHAN];
    logic        [MAX_OS-1:0]    r_cnt_mem [N_CHAN];

    logic                        r_vld_p0;
    logic        [W_CHAN-1:0]    r_chan_p0;
    logic signed [W_DATA-1:0]    r_data_p0;

    logic                        r_vld_p1;
    logic        [W_CHAN-1:0]    r_chan_p1;
    logic signed [W_DATA-1:0]    r_data_p1;
    logic        [W_OS-1:0]      r_os_p1;
    logic signed [W_SUM-1:0]     r_sum_p1;
    logic        [MAX_OS-1:0]    r_cnt_p1;

    logic                        r_dv_p2;
    logic        [W_CHAN-1:0]    r_chan_p2;
    logic signed [W_DATA-1:0]    r_data_p2;

    logic                        w_cfg;
    logic        [CHAN_IDX_W-1:0] w_cfg_idx;
    logic        [W_OS-1:0]      w_cfg_os;
    logic                        w_unused_wr_data;
    logic        [CHAN_IDX_W-1:0] w_idx_p0;
    logic        [CHAN_IDX_W-1:0] w_idx_p1;
    logic        [W_OS-1:0]      w_os_f;
    logic signed [W_SUM-1:0]     w_sum_f;
    logic        [MAX_OS-1:0]    w_cnt_f;
    logic signed [W_SUM-1:0]     w_nsum_p1;
    logic                        w_last_p1;
    logic                        w_wb_en;
    logic signed [W_SUM-1:0]     w_wb_sum;
    logic        [MAX_OS-1:0]    w_wb_cnt;

    assign w_cfg            = wr_en && (wr_addr == W_WR_ADDR'(OS_ADDR))
                              && (wr_chan < W_WR_CHAN'(N_CHAN));
    assign w_cfg_idx        = wr_chan[CHAN_IDX_W-1:0];
    assign w_cfg_os         = f_clamp_os(wr_data[W_OS-1:0]);
    assign w_unused_wr_data = ^wr_data[W_WR_DATA-1:W_OS];

    // Stage 1: register the sample
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_vld_p0 <= 1'b0;
        else         r_vld_p0 <= dv_in && (chan_in < W_CHAN'(N_CHAN));
    end

    always_ff @(posedge clk_in) begin
        r_chan_p0 <= chan_in;
        r_data_p0 <= data_in;
    end

    assign w_idx_p0 = r_chan_p0[CHAN_IDX_W-1:0];
    assign w_idx_p1 = r_chan_p1[CHAN_IDX_W-1:0];

    // A config write on the fetched channel overrides a same-cycle writeback:
    // this sample becomes the first of the freshly cleared window.
    always_comb begin
        w_os_f  = r_os_mem[w_idx_p0];
        w_sum_f = r_sum_mem[w_idx_p0];
        w_cnt_f = r_cnt_mem[w_idx_p0];
        if (w_wb_en && (w_idx_p1 == w_idx_p0)) begin
            w_sum_f = w_wb_sum;
            w_cnt_f = w_wb_cnt;
        end
        if (w_cfg && (w_cfg_idx == w_idx_p0)) begin
            w_os_f  = w_cfg_os;
            w_sum_f = '0;
            w_cnt_f = '0;
        end
    end

    // Stage 1 -> 2: fetched channel state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_vld_p1 <= 1'b0;
        else         r_vld_p1 <= r_vld_p0;
    end

    always_ff @(posedge clk_in) begin
        r_chan_p1 <= r_chan_p0;
        r_data_p1 <= r_data_p0;
        r_os_p1   <= w_os_f;
        r_sum_p1  <= w_sum_f;
        r_cnt_p1  <= w_cnt_f;
    end

    // Stage 2: accumulate; a config write to this channel discards the sample
    assign w_nsum_p1 = r_sum_p1 + W_SUM'(r_data_p1);
    assign w_last_p1 = (r_cnt_p1 == f_win_last(r_os_p1));
    assign w_wb_en   = r_vld_p1 && !(w_cfg && (w_cfg_idx == w_idx_p1));
    assign w_wb_sum  = w_last_p1 ? '0 : w_nsum_p1;
    assign w_wb_cnt  = w_last_p1 ? '0 : r_cnt_p1 + MAX_OS'(1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_os_mem[i]  <= '0;
                r_sum_mem[i] <= '0;
                r_cnt_mem[i] <= '0;
            end
        end else begin
            if (w_wb_en) begin
                r_sum_mem[w_idx_p1] <= w_wb_sum;
                r_cnt_mem[w_idx_p1] <= w_wb_cnt;
            end
            if (w_cfg) begin
                r_os_mem[w_cfg_idx]  <= w_cfg_os;
                r_sum_mem[w_cfg_idx] <= '0;
                r_cnt_mem[w_cfg_idx] <= '0;
            end
        end
    end

    // Stage 2 -> output: averaged sample, held between pulses
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_dv_p2   <= 1'b0;
            r_chan_p2 <= '0;
            r_data_p2 <= '0;
        end else begin
            r_dv_p2 <= w_wb_en && w_last_p1;
            if (w_wb_en && w_last_p1) begin
                r_chan_p2 <= r_chan_p1;
                r_data_p2 <= f_avg(w_nsum_p1, r_os_p1);
            end
        end
    end

    assign dv_out   = r_dv_p2;
    assign chan_out = r_chan_p2;
    assign data_out = r_data_p2;

endmodule

// File: doc/oversample_filter.md
# oversample_filter

Per-channel block-averaging decimator directly upstream of the PID filter. It accumulates 2^os consecutive valid samples for each channel, with os set per channel. When a channel's window completes, it emits one averaged sample on the same dv/chan/data stream that the PID filter consumes. Channel configuration uses the shared wr_en/wr_addr/wr_chan/wr_data write bus.

## Interface
- W_CHAN, 5: channel index width; N_CHAN (from parameters.vh) channels are active.
- W_DATA, 18: signed sample width, both in and out.
- MAX_OS, 10: maximum log2 oversample ratio.
- W_OS, 4: width of the stored os value; must satisfy 2^W_OS > MAX_OS.
- W_WR_ADDR, 16 / W_WR_CHAN, 16 / W_WR_DATA, 48: write-bus widths.
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- dv_in  input  1  input sample valid; single-cycle qualifier.
- chan_in  input  W_CHAN  input sample channel.
- data_in  input  W_DATA  signed input sample.
- wr_en  input  1  write strobe; one cycle high per write.
- wr_addr  input  W_WR_ADDR  register address; this block decodes OS_ADDR only.
- wr_chan  input  W_WR_CHAN  target channel.
- wr_data  input  W_WR_DATA  write data; bits [W_OS-1:0] are used.
- dv_out  output  1  averaged sample valid.
- chan_out  output  W_CHAN  averaged sample channel.
- data_out  output  W_DATA  signed averaged sample.

## Operation
- Per-channel state:
  - os_mem[W_OS]: configuration.
  - sum_mem: signed, width W_SUM = W_DATA+MAX_OS.
  - cnt_mem[MAX_OS]: samples accumulated so far in the current window.
- Stage 1, on dv_in:
  - Register chan_in and data_in.
  - Fetch os, sum and cnt for chan_in.
- Stage 2 computes nsum = sum + sign-extended data.
- Window complete (cnt == 2^os − 1):
  - Assert dv_out with data_out = nsum >>> os. The shift is arithmetic; rounding is floor toward −∞.
  - Write sum=0 and cnt=0 back for that channel.
- Window not complete: write sum=nsum and cnt=cnt+1 back; dv_out stays 0.
- os = 0 is passthrough: every valid sample is output unchanged.
- Forwarding: if stage 1 fetches the channel that stage 2 is writing back in the same cycle, stage 1 uses the written-back values, not the memory values. Back-to-back same-channel samples must accumulate correctly.
- Config write: when wr_en=1 and wr_addr==OS_ADDR and wr_chan<N_CHAN:
  - os_mem[wr_chan] gets min(wr_data[W_OS-1:0], MAX_OS).
  - sum_mem[wr_chan] and cnt_mem[wr_chan] are cleared.
- Writes with any other address, or with wr_chan ≥ N_CHAN, are ignored.
- Write and sample collide on the same channel:
  - If the colliding sample is in stage 2 in the write cycle, the clear wins: it produces no output and is not accumulated.
  - If the sample is in stage 1 in the write cycle, it is the first sample of the new window under the new os.
- Samples with chan_in ≥ N_CHAN are dropped.
- Overflow is impossible by construction: W_SUM holds 2^MAX_OS full-scale samples.

## Timing
- Latency: 2 clk_in cycles from the dv_in edge that completes a window to dv_out=1.
- dv_out is a 1-cycle pulse; chan_out and data_out hold their last values between pulses.
- Throughput is one sample per cycle, any channel order; there is no backpressure.
- Config writes take effect for samples arriving 1 cycle or more after the write edge.
- Reset (rst_in=0, asynchronous): dv_out=0, chan_out=0, data_out=0, and all os/sum/cnt memories are 0 (passthrough).
- Reset mid-window discards partial sums; the first output after release follows the os=0 rule.

## Structure
- Shared parameters.vh holds N_CHAN, OS_ADDR and MAX_OS; PID and routing blocks already share the address map.
- No sub-module: memories plus a two-stage pipeline in one file; the forwarding mux is inline.

## Test plan
- Reset with no config: ch0 samples 100, −5, 7 → outputs 100, −5, 7 on ch0, each 2 cycles after its input.
- os[3]=2; ch3 samples 10, 20, 30, 41 back-to-back → exactly one dv_out: chan 3, data 25 (101>>>2), 2 cycles after the 4th sample.
- os[1]=1, os[2]=1; interleaved samples ch1:4, ch2:−3, ch1:6, ch2:−4 → outputs ch1=5, then ch2=−4 (floor of −3.5).
- os[0]=10; 1024 samples of +131071 → one output 131071. Repeat with −131072 → one output −131072 (no overflow).
- os[5]=2; three samples, then rewrite os[5]=1, then samples 8, 9 → one output 8, and the stale partial sum is gone. Write os=15 → reads back as MAX_OS behaviour (1024-sample window).
- Forwarding: os[7]=3, eight consecutive ch7 samples 1..8 → output 4 (36>>>3). Collision: write OS_ADDR on ch7 in the same cycle that sample 8 is in stage 2 → no output, and the next window starts clean.
- Assert rst_in low for 1 cycle mid-window (os[4]=2, two samples in) → outputs zero immediately; next ch4 sample 9 → output 9.
